// File: rtl/sram_responder_pkg.sv
// Shared types for the sram responder: FSM state encoding and wait counter width.
package includes;
    typedef enum logic {RESP_IDLE, RESP_WAIT} resp_state;
    localparam int RESP_CNT_W = 4;
endpackage

// File: rtl/sram_if.sv
// Single-master sram bus; master presents a request, slave answers with stall/data_r.
interface sram;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;

    modport master (output en, output we, output addr, output data_w,
                    input stall, input data_r);
    modport slave  (input en, input we, input addr, input data_w,
                    output stall, output data_r);
endinterface

// File: rtl/sram_array.sv
// Synchronous single-port word array with registered read; no reset so it maps to block RAM.
module sram_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];

    // Writes leave rdata untouched so the last read value stays visible.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[idx] <= wdata;
            else
                rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/sram_responder.sv
// Responder for the sram bus: word array behind a programmable wait-state FSM,
// flagging misaligned or out-of-range accesses through a one-cycle err pulse.
module sram_responder
    import includes::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    sram.slave   bus,
    output logic err
);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH) << 2;
    localparam logic        ZERO_WAIT = (LATENCY == 0);

    resp_state               state_reg;
    logic [RESP_CNT_W-1:0]   cnt_reg;
    logic                    err_reg;
    logic                    zero_reg;
    logic [31:0]             off;
    logic                    bad;
    logic                    accept;
    logic                    arr_en;
    logic [31:0]             rdata;

    assign off = bus.addr - BASE;
    assign bad = (bus.addr[1:0] != 2'b00) || (off >= SPAN);

    assign accept = (state_reg == RESP_IDLE) ? (bus.en && ZERO_WAIT) : (cnt_reg == '0);
    assign bus.stall = (state_reg == RESP_IDLE) ? (bus.en && !ZERO_WAIT) : (cnt_reg != '0);

    // Gate with rst so a zero-wait request cannot write while reset is held.
    assign arr_en = accept && !bad && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RESP_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            err_reg <= accept && bad;
            // zero_reg masks stale array read data after errors; writes leave it alone.
            if (accept) begin
                if (bad)
                    zero_reg <= 1'b1;
                else if (!bus.we)
                    zero_reg <= 1'b0;
            end
            case (state_reg)
                RESP_IDLE: begin
                    if (bus.en && !ZERO_WAIT) begin
                        cnt_reg   <= RESP_CNT_W'(LATENCY - 1);
                        state_reg <= RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    if (cnt_reg != '0)
                        cnt_reg <= cnt_reg - RESP_CNT_W'(1);
                    else
                        state_reg <= RESP_IDLE;
                end
                default: state_reg <= RESP_IDLE;
            endcase
        end
    end

    sram_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (bus.we),
        .idx   (off[IDX_W+1:2]),
        .wdata (bus.data_w),
        .rdata (rdata)
    );

    assign bus.data_r = zero_reg ? 32'h0 : rdata;
    assign err        = err_reg;
endmodule

// File: doc/sram_responder.md
# sram_responder

Responder end of the `sram` bus: serves one master (the datapath's instruction or data port) from an internal word array with a programmable number of wait states. It signals those wait states through `stall`. It also flags misaligned or out-of-range accesses. One instance sits behind `ibus_sram` and a second behind `dbus_sram` in the SoC top and in the core testbench, replacing ideal single-cycle memory models.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array; power of two, 16..65536.
- `LATENCY`, 2: wait states per access, 0..15.
- `BASE`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH*4`.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `bus` sram.slave:
  - Drives `stall` and `data_r`.
  - Samples `en`, `we`, `addr` and `data_w`.
- `err` output, 1 bit: one-cycle pulse marking a rejected access, aligned with that access's `data_r` cycle.

## Operation
- **FSM states:** `IDLE` and `WAIT`, plus a 4-bit down-counter `cnt`.
- **IDLE, en=0:** `stall=0`; no action.
- **IDLE, en=1, LATENCY=0:**
  - `stall=0`.
  - The access is accepted at this edge.
  - State stays `IDLE`.
- **IDLE, en=1, LATENCY>0:**
  - `stall=1`, driven combinationally from `en`.
  - At the edge, `cnt <= LATENCY-1` and the FSM enters `WAIT`.
- **WAIT:**
  - `stall = (cnt != 0)`.
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: `stall=0`, the access is accepted at this edge, and the FSM returns to `IDLE`.
- **Acceptance:**
  - Exactly one access per request.
  - The responder uses `we`/`addr`/`data_w` as presented on the accept edge.
  - The master holds them stable while `stall=1`.
  - If `en` drops while in `WAIT`, the access still completes.
- **Index:** `idx = (addr - BASE) >> 2`, truncated to `$clog2(DEPTH)` bits.
- **Error condition:** `addr[1:0] != 0`, or `addr - BASE >= DEPTH*4` (unsigned 32-bit compare).
  - On error: no array access, `data_r <= 0`, and `err` pulses for one cycle.
- **Read (we=0), valid address:** `data_r <= mem[idx]`.
- **Write (we=1), valid address:** `mem[idx] <= data_w`; `data_r` holds its previous value.
- **data_r hold:** `data_r` changes only on accept edges (and reset); it is held between accepts.

## Timing
- **Reset values** (while `rst=0`, asynchronously):
  - State `IDLE`, `cnt=0`, `data_r=0`, `err=0`.
  - `stall` follows `en` per the `IDLE` rule.
  - Array contents are not reset.
- **Request latency:**
  - `en` rises in cycle 0.
  - `stall=1` for cycles 0..LATENCY-1.
  - Accept at the end of cycle LATENCY.
  - Read data is on `data_r` in cycle LATENCY+1.
  - This matches the datapath's "consume next stage" use of `data_r`.
- **LATENCY=0:** zero-wait, fully pipelined; one access per cycle with `stall` never asserted.
- **Back-to-back:**
  - After an accept, a new `en` in the next cycle starts a fresh wait in `IDLE`.
  - Throughput is one access per LATENCY+1 cycles.
- **Read-after-write to the same word:** the read accepted in the cycle after the write returns the new data (the array is written at the write's accept edge).
- **Reset mid-WAIT:**
  - The pending access is discarded; the array is unmodified.
  - After release with `en` still high, a full new LATENCY wait begins.
- **err:** high only in the cycle following an erroneous accept; never two cycles for one access.

## Structure
- In package `includes`:
  - `typedef enum logic {RESP_IDLE, RESP_WAIT} resp_state;`
  - Constant `RESP_CNT_W = 4`.
- Sub-module `sram_array #(DEPTH)`:
  - Synchronous single-port word array.
  - Ports: `clk`, `en`, `we`, `idx`, `wdata`, `rdata`.
  - Registered read, no reset.
  - Keeps the array inferable as block RAM.
- The FSM, counter, address check, `err` and `stall` logic live in `sram_responder`.

## Test plan
- **Read latency:** LATENCY=2, BASE=0, mem[4]=32'hDEAD_BEEF; `en=1, we=0, addr=32'h10` at cycle 0 -> `stall=1` in cycles 0-1, `stall=0` in cycle 2, `data_r=32'hDEAD_BEEF` in cycle 3, `err=0`.
- **Zero-wait writes:** LATENCY=0; write 32'h1234_5678 to 32'h20, then read 32'h20 in the next cycle -> `stall` never 1; `data_r=32'h1234_5678` one cycle after the read.
- **Misaligned:** `addr=32'h13`, `we=1` -> after LATENCY waits, `err=1` for exactly one cycle, `data_r=0`, word 4 unchanged on readback.
- **Out of range:** DEPTH=1024, BASE=32'h1000, `addr=32'h2000` -> `err` pulse and `data_r=0`; `addr=32'h0FFC` -> `err` pulse.
- **Reset mid-WAIT:**
  - LATENCY=5, write 32'hAAAA_AAAA to 32'h8; assert `rst=0` in cycle 2, release in cycle 3 with `en` still high -> `stall=1` for 5 more cycles, then one write.
  - A prior reset-free readback of 32'h8 shows the old value was intact until that write.
- **Back-to-back reads:** LATENCY=1, reads of 32'h0 then 32'h4 with `en` held high -> `stall` pattern 1,0,1,0; `data_r` shows mem[0] then mem[1], each held until the next accept.
